// File: rtl/ip_learn_requester.sv
// Look-up/insert initiator for the IP hash controller: issues look-ups, tracks fixed-latency
// responses and queues misses for write-back. Optional statistics counters: IP_LEARN_STATS_EN.
module ip_learn_requester #(
  parameter int IP_ADDR_W       = 32,
  parameter int LOOKUP_LAT      = 2,
  parameter int MISS_FIFO_DEPTH = 4,
  parameter int CNT_W           = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ip_valid_i,
  input  logic [IP_ADDR_W-1:0] ip_addr_i,
  output logic                 ip_ready_o,
  input  logic                 learn_en_i,
  output logic                 look_up_val_o,
  output logic                 insert_val_o,
  output logic [IP_ADDR_W-1:0] ip_addr_o,
  input  logic                 found_valid_i,
  input  logic                 found_i,
  output logic [CNT_W-1:0]     hit_cnt_o,
  output logic [CNT_W-1:0]     miss_cnt_o,
  output logic [CNT_W-1:0]     insert_cnt_o,
  output logic                 err_o
);

  localparam int PTR_W    = (MISS_FIFO_DEPTH > 1) ? $clog2(MISS_FIFO_DEPTH) : 1;
  localparam int CNT_FW   = $clog2(MISS_FIFO_DEPTH + 1);
  localparam int RECENT_N = LOOKUP_LAT + 1;
  localparam int GUARD_W  = $clog2(LOOKUP_LAT + 2);
  localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(LOOKUP_LAT + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MISS_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Request register
  logic                 look_up_val_q;
  logic                 insert_val_q;
  logic [IP_ADDR_W-1:0] addr_q;

  // Reset guard, in-flight tracker, miss FIFO and recent-insert history
  logic [GUARD_W-1:0]    guard_q, guard_d;
  logic [LOOKUP_LAT-1:0] trk_vld_q;
  logic [IP_ADDR_W-1:0]  trk_addr_q [LOOKUP_LAT];
  logic [MISS_FIFO_DEPTH-1:0] fifo_vld_q;
  logic [IP_ADDR_W-1:0]  fifo_mem_q [MISS_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_FW-1:0]     count_q, count_d;
  logic [RECENT_N-1:0]   recent_vld_q;
  logic [IP_ADDR_W-1:0]  recent_addr_q [RECENT_N];
  logic                  err_q;

  logic                 guard_done, fifo_empty, fifo_full;
  logic                 handshake, pop, push_req, push, dup;
  logic                 exp_vld, resp_ok, is_miss, err_set;
  logic [IP_ADDR_W-1:0] exp_addr, head_addr;

  assign guard_done = (guard_q == '0);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FW'(MISS_FIFO_DEPTH));
  assign head_addr  = fifo_mem_q[rd_ptr_q];

  // Ready depends only on flops so the parser never sees a valid->ready loop.
  assign ip_ready_o = fifo_empty && guard_done;
  assign handshake  = ip_valid_i && ip_ready_o;
  assign pop        = !fifo_empty;

  assign exp_vld  = trk_vld_q[LOOKUP_LAT-1];
  assign exp_addr = trk_addr_q[LOOKUP_LAT-1];
  assign resp_ok  = guard_done && exp_vld && found_valid_i;
  assign is_miss  = resp_ok && !found_i;

  // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < MISS_FIFO_DEPTH; i++) begin
      if (fifo_vld_q[i] && (fifo_mem_q[i] == exp_addr)) dup = 1'b1;
    end
    for (int i = 0; i < RECENT_N; i++) begin
      if (recent_vld_q[i] && (recent_addr_q[i] == exp_addr)) dup = 1'b1;
    end
  end

  assign push_req = is_miss && learn_en_i && !dup;
  assign push     = push_req && !fifo_full;
  assign err_set  = (guard_done && ((found_valid_i && !exp_vld) || (exp_vld && !found_valid_i)))
                  || (push_req && fifo_full);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase
  end

  assign guard_d = guard_done ? guard_q : guard_q - GUARD_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      look_up_val_q <= 1'b0;
      insert_val_q  <= 1'b0;
      addr_q        <= '0;
    end else if (pop) begin
      look_up_val_q <= 1'b0;
      insert_val_q  <= 1'b1;
      addr_q        <= head_addr;
    end else if (handshake) begin
      look_up_val_q <= 1'b1;
      insert_val_q  <= 1'b0;
      addr_q        <= ip_addr_i;
    end else begin
      look_up_val_q <= 1'b0;
      insert_val_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      guard_q      <= GUARD_INIT;
      trk_vld_q    <= '0;
      fifo_vld_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      recent_vld_q <= '0;
      err_q        <= 1'b0;
    end else begin
      guard_q      <= guard_d;
      count_q      <= count_d;
      err_q        <= err_q | err_set;
      trk_vld_q[0] <= look_up_val_q;
      for (int i = 1; i < LOOKUP_LAT; i++) trk_vld_q[i] <= trk_vld_q[i-1];
      if (push) begin
        fifo_vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        fifo_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q             <= ptr_inc(rd_ptr_q);
        recent_vld_q[0]      <= 1'b1;
        for (int i = 1; i < RECENT_N; i++) recent_vld_q[i] <= recent_vld_q[i-1];
      end
    end
  end

  // NOTE: address storage has no reset; the valid bits above qualify every entry.
  always_ff @(posedge clk) begin
    trk_addr_q[0] <= addr_q;
    for (int i = 1; i < LOOKUP_LAT; i++) trk_addr_q[i] <= trk_addr_q[i-1];
    if (push) fifo_mem_q[wr_ptr_q] <= exp_addr;
    if (pop) begin
      recent_addr_q[0] <= head_addr;
      for (int i = 1; i < RECENT_N; i++) recent_addr_q[i] <= recent_addr_q[i-1];
    end
  end

  assign look_up_val_o = look_up_val_q;
  assign insert_val_o  = insert_val_q;
  assign ip_addr_o     = addr_q;
  assign err_o         = err_q;

`ifdef IP_LEARN_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, insert_cnt_q;
  logic             is_hit;

  assign is_hit = resp_ok && found_i;

  // Saturating counters: they stick at all-ones rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      insert_cnt_q <= '0;
    end else begin
      if (is_hit && (hit_cnt_q != '1))     hit_cnt_q    <= hit_cnt_q + CNT_W'(1);
      if (is_miss && (miss_cnt_q != '1))   miss_cnt_q   <= miss_cnt_q + CNT_W'(1);
      if (pop && (insert_cnt_q != '1))     insert_cnt_q <= insert_cnt_q + CNT_W'(1);
    end
  end

  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;
  assign insert_cnt_o = insert_cnt_q;
`else
  assign hit_cnt_o    = '0;
  assign miss_cnt_o   = '0;
  assign insert_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ip_learn_requester.sv
// Self-checking bench for ip_learn_requester: directed scenarios plus randomized traffic
// compared every cycle against a queue-based transaction model.
`timescale 1ns/1ps
module tb_ip_learn_requester;

  localparam int AW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ip_valid_i;
  logic [AW-1:0] ip_addr_i;
  logic          ip_ready_o;
  logic          learn_en_i;
  logic          look_up_val_o;
  logic          insert_val_o;
  logic [AW-1:0] ip_addr_o;
  logic          found_valid_i;
  logic          found_i;
  logic [CW-1:0] hit_cnt_o, miss_cnt_o, insert_cnt_o;
  logic          err_o;

  always #5 clk = ~clk;

  ip_learn_requester #(
    .IP_ADDR_W(AW), .LOOKUP_LAT(LAT), .MISS_FIFO_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .ip_valid_i(ip_valid_i), .ip_addr_i(ip_addr_i), .ip_ready_o(ip_ready_o),
    .learn_en_i(learn_en_i),
    .look_up_val_o(look_up_val_o), .insert_val_o(insert_val_o), .ip_addr_o(ip_addr_o),
    .found_valid_i(found_valid_i), .found_i(found_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .insert_cnt_o(insert_cnt_o),
    .err_o(err_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: outstanding look-ups with due cycle, miss queue, insert history.
  typedef struct { logic [AW-1:0] addr; int due; } pend_t;
  pend_t         m_pend[$];
  logic [AW-1:0] m_fifo[$];
  logic [AW-1:0] m_recent[$];
  int            m_guard;
  int            cyc;
  logic          m_lv, m_iv, m_err;
  logic [AW-1:0] m_addr;
  logic [CW-1:0] m_hit, m_miss, m_ins;
  bit            hit_plan[$];
  bit            drop_next;
  bit            stray;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  function automatic logic [CW-1:0] exp_cnt(input logic [CW-1:0] v);
`ifdef IP_LEARN_STATS_EN
    return v;
`else
    return (v == v) ? '0 : '0;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_pend.delete();
    m_fifo.delete();
    m_recent.delete();
    m_guard = LAT + 1;
    cyc     = 0;
    m_lv = 1'b0; m_iv = 1'b0; m_err = 1'b0; m_addr = '0;
    m_hit = '0; m_miss = '0; m_ins = '0;
  endfunction

  function automatic void model_edge();
    bit            ready, due, dup, new_push;
    int            pre_size;
    logic [AW-1:0] resp_addr;
    ready     = (m_fifo.size() == 0) && (m_guard == 0);
    due       = (m_pend.size() > 0) && (m_pend[0].due == cyc);
    pre_size  = m_fifo.size();
    dup       = 1'b0;
    new_push  = 1'b0;
    resp_addr = '0;
    if (due) begin
      resp_addr = m_pend[0].addr;
      foreach (m_fifo[i])   if (m_fifo[i] == resp_addr)   dup = 1'b1;
      foreach (m_recent[i]) if (m_recent[i] == resp_addr) dup = 1'b1;
    end
    if (m_guard == 0) begin
      if (found_valid_i && !due) m_err = 1'b1;
      if (due && !found_valid_i) m_err = 1'b1;
      if (due && found_valid_i) begin
        if (found_i) m_hit = sat_inc(m_hit);
        else begin
          m_miss = sat_inc(m_miss);
          if (learn_en_i && !dup) new_push = 1'b1;
        end
      end
    end
    if (due) void'(m_pend.pop_front());
    if (pre_size > 0) begin
      m_iv   = 1'b1;
      m_lv   = 1'b0;
      m_addr = m_fifo.pop_front();
      m_recent.push_back(m_addr);
      if (m_recent.size() > LAT + 1) void'(m_recent.pop_front());
      m_ins = sat_inc(m_ins);
    end else if (ip_valid_i && ready) begin
      m_lv   = 1'b1;
      m_iv   = 1'b0;
      m_addr = ip_addr_i;
      m_pend.push_back('{ip_addr_i, cyc + 1 + LAT});
    end else begin
      m_lv = 1'b0;
      m_iv = 1'b0;
    end
    if (new_push) begin
      if (pre_size == DEPTH) m_err = 1'b1;
      else m_fifo.push_back(resp_addr);
    end
    if (m_guard > 0) m_guard--;
  endfunction

  task automatic compare_all();
    check("ip_ready",    ip_ready_o,    (m_fifo.size() == 0) && (m_guard == 0));
    check("look_up_val", look_up_val_o, m_lv);
    check("insert_val",  insert_val_o,  m_iv);
    check("ip_addr",     ip_addr_o,     m_addr);
    check("err",         err_o,         m_err);
    check("valid_excl",  look_up_val_o & insert_val_o, 1'b0);
    check("hit_cnt",     hit_cnt_o,     exp_cnt(m_hit));
    check("miss_cnt",    miss_cnt_o,    exp_cnt(m_miss));
    check("insert_cnt",  insert_cnt_o,  exp_cnt(m_ins));
  endtask

  // One clock cycle: act as the controller, advance the model, then compare.
  task automatic step();
    bit due;
    due           = (m_pend.size() > 0) && (m_pend[0].due == cyc);
    found_valid_i = 1'b0;
    found_i       = 1'b0;
    if (due) begin
      if (drop_next) drop_next = 1'b0;
      else begin
        found_valid_i = 1'b1;
        if (hit_plan.size() > 0) found_i = hit_plan.pop_front();
        else found_i = 1'($urandom_range(0, 1));
      end
    end
    if (stray) begin
      found_valid_i = 1'b1;
      stray         = 1'b0;
    end
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  initial begin
    int ins_seen;
    int first_ins;
    int last_ins;
    logic [AW-1:0] ins_addr[$];

    ip_valid_i    = 1'b0;
    ip_addr_i     = '0;
    learn_en_i    = 1'b1;
    found_valid_i = 1'b0;
    found_i       = 1'b0;
    drop_next     = 1'b0;
    stray         = 1'b0;
    model_reset();

    // Reset state, then release into the guard window with a stray response in it.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
    check("ready_guard_c0", ip_ready_o, 1'b0);
    step();
    stray = 1'b1;
    step();
    check("ready_guard_c2", ip_ready_o, 1'b0);
    step();
    check("err_after_stray", err_o, 1'b0);
    check("ready_after_guard", ip_ready_o, 1'b1);

    // Single hit accepted in cycle 10, single miss accepted in cycle 11.
    while (cyc < 10) step();
    hit_plan.push_back(1'b1);
    ip_valid_i = 1'b1;
    ip_addr_i  = 32'h0A00_0001;
    step();
    check("hit_lookup_val", look_up_val_o, 1'b1);
    check("hit_lookup_addr", ip_addr_o, 32'h0A00_0001);
    hit_plan.push_back(1'b0);
    ip_addr_i = 32'hC0A8_0001;
    step();
    ip_valid_i = 1'b0;
    step();
    step();
    check("hit_cnt_after_hit", hit_cnt_o, exp_cnt(CW'(1)));
    check("no_insert_on_hit", insert_val_o, 1'b0);
    step();
    check("ready_low_after_miss", ip_ready_o, 1'b0);
    step();
    check("miss_insert_val", insert_val_o, 1'b1);
    check("miss_insert_addr", ip_addr_o, 32'hC0A8_0001);
    check("insert_cnt_one", insert_cnt_o, exp_cnt(CW'(1)));
    repeat (4) step();

    // Burst of three misses, two to the same address.
    ip_valid_i = 1'b1;
    ip_addr_i = 32'h0101_0101; hit_plan.push_back(1'b0); step();
    ip_addr_i = 32'h0202_0202; hit_plan.push_back(1'b0); step();
    ip_addr_i = 32'h0101_0101; hit_plan.push_back(1'b0); step();
    ip_valid_i = 1'b0;
    ins_seen  = 0;
    first_ins = -1;
    last_ins  = -1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (insert_val_o) begin
        ins_seen++;
        ins_addr.push_back(ip_addr_o);
        if (first_ins < 0) first_ins = cyc;
        last_ins = cyc;
      end
    end
    check("burst_insert_count", ins_seen, 2);
    check("burst_back_to_back", last_ins - first_ins, 1);
    if (ins_addr.size() == 2) begin
      check("burst_ins0_addr", ins_addr[0], 32'h0101_0101);
      check("burst_ins1_addr", ins_addr[1], 32'h0202_0202);
    end
    check("burst_miss_cnt", miss_cnt_o, exp_cnt(CW'(4)));
    check("burst_ready_resumed", ip_ready_o, 1'b1);

    // Miss with learning disabled produces no insert.
    learn_en_i = 1'b0;
    ip_valid_i = 1'b1;
    ip_addr_i  = 32'h0B0B_0B0B;
    hit_plan.push_back(1'b0);
    step();
    ip_valid_i = 1'b0;
    ins_seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (insert_val_o) ins_seen++;
    end
    check("nolearn_no_insert", ins_seen, 0);
    learn_en_i = 1'b1;

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      ip_valid_i = ($urandom_range(0, 3) != 0);
      ip_addr_i  = 32'h0A00_0000 + AW'($urandom_range(0, 7));
      learn_en_i = ($urandom_range(0, 7) != 0);
      step();
    end
    ip_valid_i = 1'b0;
    learn_en_i = 1'b1;
    repeat (10) step();
    check("err_clean_after_random", err_o, 1'b0);

    // Dropped response sets a sticky error.
    drop_next  = 1'b1;
    ip_valid_i = 1'b1;
    ip_addr_i  = 32'h0C0C_0C0C;
    step();
    ip_valid_i = 1'b0;
    repeat (4) step();
    check("err_on_drop", err_o, 1'b1);
    repeat (5) step();
    check("err_sticky", err_o, 1'b1);

    // Reset asserted mid-burst clears everything at once.
    ip_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ip_addr_i = 32'h0D00_0000 + AW'(k);
      hit_plan.push_back(1'b0);
      step();
    end
    step();
    #3;
    rst = 1'b1;
    #1;
    check("rst_look_up_val", look_up_val_o, 1'b0);
    check("rst_insert_val", insert_val_o, 1'b0);
    check("rst_ip_addr", ip_addr_o, '0);
    check("rst_ready", ip_ready_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_miss_cnt", miss_cnt_o, '0);
    ip_valid_i    = 1'b0;
    found_valid_i = 1'b0;
    found_i       = 1'b0;
    hit_plan.delete();
    drop_next = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
    repeat (LAT + 1) step();
    check("post_rst_ready", ip_ready_o, 1'b1);
    hit_plan.push_back(1'b1);
    ip_valid_i = 1'b1;
    ip_addr_i  = 32'h0A00_0001;
    step();
    ip_valid_i = 1'b0;
    repeat (5) step();
    check("post_rst_err", err_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
